// File: rtl/run_sched_pkg.sv
// Shared state encoding and a state-name decode for run_sched.
package run_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    LAST = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } state_t;

  // Four-character ASCII tag for a state, handy when printing from a bench.
  function automatic logic [31:0] state_name(input state_t s);
    case (s)
      IDLE:    state_name = "IDLE";
      LOAD:    state_name = "LOAD";
      RUN:     state_name = "RUN ";
      LAST:    state_name = "LAST";
      GAP:     state_name = "GAP ";
      DONE:    state_name = "DONE";
      default: state_name = "ILL?";
    endcase
  endfunction

endpackage

// File: rtl/run_sched.sv
// Burst sequencer: LOAD, then bursts x (RUN x len, LAST) with GAP between
// bursts, then DONE. All outputs are registered and decoded from nstate so
// each value lines up with the state it describes.
module run_sched
  import run_sched_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int BURST_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   run_len,
  input  logic [BURST_W-1:0] bursts,
  input  logic               abort,
  output logic               busy,
  output logic               run_en,
  output logic [CNT_W-1:0]   cnt,
  output logic [BURST_W-1:0] burst_idx,
  output logic               phase,
  output logic               done,
  output logic               err
);

  state_t             state, nstate;
  logic [CNT_W-1:0]   len_q;
  logic [BURST_W-1:0] bursts_q;
  logic               accept;

  // A start is only taken in IDLE and only with a nonzero burst count.
  assign accept = (state == IDLE) && start && (bursts != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (accept) nstate = LOAD;
      LOAD: nstate = RUN;
      RUN:  if (cnt == len_q - CNT_W'(1)) nstate = LAST;
      LAST: nstate = (burst_idx == bursts_q - BURST_W'(1)) ? DONE : GAP;
      GAP:  nstate = RUN;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (abort && state != IDLE) nstate = IDLE;
  end

  // Latch the burst shape on an accepted start; a zero length runs one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      bursts_q <= '0;
    end else if (accept) begin
      len_q    <= (run_len == '0) ? CNT_W'(1) : run_len;
      bursts_q <= bursts;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      run_en    <= 1'b0;
      cnt       <= '0;
      burst_idx <= '0;
      phase     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy   <= (nstate != IDLE);
      run_en <= (nstate == RUN);
      done   <= (nstate == DONE);
      err    <= (state == IDLE) && start && (bursts == '0);
      cnt    <= (nstate == RUN && state == RUN) ? cnt + CNT_W'(1) : '0;
      if (nstate == LOAD)                    burst_idx <= '0;
      else if (nstate == GAP)                burst_idx <= burst_idx + BURST_W'(1);
      if (nstate == LAST && state != LAST)   phase     <= ~phase;
    end
  end

endmodule

// File: tb/tb_run_sched.sv
// Self-checking bench for run_sched: directed vector table, an async reset
// sequence, then random stimulus against a sequence-expansion model.
module tb_run_sched;
  import run_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [3:0] run_len;
  logic [2:0] bursts;
  logic       busy, run_en, phase, done, err;
  logic [3:0] cnt;
  logic [2:0] burst_idx;

  run_sched #(.CNT_W(4), .BURST_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_len(run_len),
    .bursts(bursts), .abort(abort), .busy(busy), .run_en(run_en),
    .cnt(cnt), .burst_idx(burst_idx), .phase(phase), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // {busy, run_en, cnt[3:0], burst_idx[2:0], phase, done, err}
  logic [11:0] got;
  assign got = {busy, run_en, cnt, burst_idx, phase, done, err};

  int ntests = 0;
  int nfail  = 0;

  function automatic logic [11:0] pk(input logic b, input logic r, input int c,
                                     input int bi, input logic ph, input logic d,
                                     input logic e);
    pk = {b, r, 4'(c), 3'(bi), ph, d, e};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s t=%0t state=%s got=%03h want=%03h", name, $time,
               state_name(dut.state), act, expv);
    end
  endtask

  // Reference model: an accepted start expands into the full list of
  // per-cycle output records; each clock pops one.
  logic [11:0] cur;
  logic [11:0] q[$];

  task automatic model_reset();
    q.delete();
    cur = '0;
  endtask

  task automatic model_step(input logic s, input logic [3:0] l, input logic [2:0] b,
                            input logic a);
    int len;
    logic ph;
    if (cur[11]) begin
      if (a || q.size() == 0) begin
        q.delete();
        cur = pk(0, 0, 0, cur[5:3], cur[2], 0, 0);
      end else begin
        cur = q.pop_front();
      end
    end else if (s && b != 0) begin
      len = (l == 0) ? 1 : int'(l);
      ph  = cur[2];
      q.push_back(pk(1, 0, 0, 0, ph, 0, 0));
      for (int bi = 0; bi < int'(b); bi++) begin
        for (int c = 0; c < len; c++) q.push_back(pk(1, 1, c, bi, ph, 0, 0));
        ph = ~ph;
        q.push_back(pk(1, 0, 0, bi, ph, 0, 0));
        if (bi < int'(b) - 1) q.push_back(pk(1, 0, 0, bi + 1, ph, 0, 0));
      end
      q.push_back(pk(1, 0, 0, int'(b) - 1, ph, 1, 0));
      cur = q.pop_front();
    end else begin
      cur = pk(0, 0, 0, cur[5:3], cur[2], 0, s && (b == 0));
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic apply(input logic s, input logic [3:0] l, input logic [2:0] b,
                       input logic a);
    start = s; run_len = l; bursts = b; abort = a;
    @(posedge clk);
    #1;
    model_step(s, l, b, a);
  endtask

  typedef struct {
    logic        s;
    logic [3:0]  l;
    logic [2:0]  b;
    logic        a;
    logic [11:0] e;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input int l, input int b, input logic a,
                              input logic [11:0] e);
    vec_t v;
    v.s = s; v.l = 4'(l); v.b = 3'(b); v.a = a; v.e = e;
    return v;
  endfunction

  initial begin
    // len 3, 2 bursts; a start with len 7 mid-run must be ignored
    tbl.push_back(mk(1, 3, 2, 0, pk(1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 7, 5, 0, pk(1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 1, 2, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 0, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 1, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 1, 1, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 1, 2, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 0, 0, 1, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, 0)));
    // len 0 -> one RUN cycle, single burst
    tbl.push_back(mk(1, 0, 1, 0, pk(1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 0, 0, 0, 1, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(0, 0, 0, 0, 1, 0, 0)));
    // zero bursts -> err pulse only
    tbl.push_back(mk(1, 5, 0, 0, pk(0, 0, 0, 0, 1, 0, 1)));
    tbl.push_back(mk(0, 5, 0, 0, pk(0, 0, 0, 0, 1, 0, 0)));
    // start+abort in IDLE still starts; abort in 2nd RUN cycle
    tbl.push_back(mk(1, 5, 3, 1, pk(1, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(1, 1, 1, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 1, pk(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, pk(0, 0, 0, 0, 1, 0, 0)));

    rst_n = 1'b0; start = 0; abort = 0; run_len = 0; bursts = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", got, 12'h000);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].s, tbl[i].l, tbl[i].b, tbl[i].a);
      check($sformatf("vec%0d", i), got, tbl[i].e);
    end

    // async reset in the middle of a RUN
    apply(1, 6, 2, 0);
    repeat (3) apply(0, 0, 0, 0);
    check("pre_rst", got, cur);
    #2 rst_n = 1'b0;
    #1 check("async_rst", got, 12'h000);
    model_reset();
    @(posedge clk);
    #1 check("rst_held", got, 12'h000);
    #2 rst_n = 1'b1;
    #2;
    apply(1, 2, 1, 0);
    check("post_rst_load", got, cur);
    repeat (5) begin
      apply(0, 0, 0, 0);
      check("post_rst_run", got, cur);
    end

    // random stimulus
    for (int n = 0; n < 3000; n++) begin
      logic s, a;
      logic [3:0] l;
      logic [2:0] b;
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 39) == 0);
      l = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      apply(s, l, b, a);
      check("rand", got, cur);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
